// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA screen constants, coordinate widths and blitter state encoding
package vga_pkg;

  localparam int VGA_SCREEN_W = 160;
  localparam int VGA_SCREEN_H = 120;
  localparam int VGA_COLOUR_W = 9;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_t;

endpackage

// File: rtl/blit_delay_line.sv
// rtl/blit_delay_line.sv - fixed-depth shift register carrying valid and coordinates alongside the ROM
//
// Ports:
//   clk, resetn   clock and synchronous active-low reset (clears every stage)
//   din           word entering stage 0 this cycle
//   dout          word that entered DEPTH cycles ago
module blit_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - streams a W x H image from a synchronous ROM to VGA pixel writes
//
// Ports:
//   clk, resetn        clock and synchronous active-low reset
//   start              blit request, honoured only while idle
//   pos_x, pos_y       top-left screen position, latched on accepted start
//   flip_x             horizontal mirror, latched on accepted start
//   rom_addr/rom_data  row-major image ROM interface (data ROM_LAT cycles after address)
//   x, y, colour, plot pixel stream to the VGA adapter
//   busy, done         handshake back to the game FSM
module sprite_blitter
  import vga_pkg::*;
#(
  parameter int IMG_W      = 80,
  parameter int IMG_H      = 40,
  parameter int COLOUR_W   = VGA_COLOUR_W,
  parameter int ROM_LAT    = 1,
  parameter int SCREEN_W   = VGA_SCREEN_W,
  parameter int SCREEN_H   = VGA_SCREEN_H,
  parameter int TRANSP_EN  = 1,
  parameter int TRANSP_KEY = 0,
  localparam int AW = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      pos_x,
  input  logic [Y_W-1:0]      pos_y,
  input  logic                flip_x,
  output logic [AW-1:0]       rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DW  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam int DLW = 1 + X_W + 1 + Y_W + 1;

  blit_state_t    state;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [AW-1:0]  row_base;
  logic [X_W-1:0] lat_pos_x;
  logic [Y_W-1:0] lat_pos_y;
  logic           lat_flip;
  logic [DW-1:0]  drain_cnt;

  logic           last_col;
  logic           last_pix;
  logic [X_W:0]   x_full_in;
  logic [Y_W:0]   y_full_in;
  logic [DLW-1:0] dl_in;
  logic [DLW-1:0] dl_out;
  logic           pix_valid;
  logic [X_W:0]   pix_x_full;
  logic [Y_W:0]   pix_y_full;
  logic           is_key;

  assign last_col  = (col == CW'(IMG_W - 1));
  assign last_pix  = last_col && (row == RW'(IMG_H - 1));
  // Screen x never mirrors; only the ROM column does.
  assign x_full_in = (X_W+1)'(lat_pos_x) + (X_W+1)'(col);
  assign y_full_in = (Y_W+1)'(lat_pos_y) + (Y_W+1)'(row);
  assign dl_in     = {state == ST_FETCH, x_full_in, y_full_in};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      lat_pos_x <= '0;
      lat_pos_y <= '0;
      lat_flip  <= 1'b0;
      drain_cnt <= '0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            busy      <= 1'b1;
            lat_pos_x <= pos_x;
            lat_pos_y <= pos_y;
            lat_flip  <= flip_x;
            col       <= '0;
            row       <= '0;
            row_base  <= '0;
            rom_addr  <= flip_x ? AW'(IMG_W - 1) : '0;
          end
        end
        ST_FETCH: begin
          if (last_pix) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end else if (last_col) begin
            col      <= '0;
            row      <= row + RW'(1);
            row_base <= row_base + AW'(IMG_W);
            // Next row starts at its left edge, or its right edge when mirrored.
            rom_addr <= row_base + AW'(IMG_W) + (lat_flip ? AW'(IMG_W - 1) : '0);
          end else begin
            col      <= col + CW'(1);
            rom_addr <= lat_flip ? rom_addr - AW'(1) : rom_addr + AW'(1);
          end
        end
        ST_DRAIN: begin
          // Last address was issued; wait ROM_LAT cycles for its pixel to emerge.
          if (drain_cnt == DW'(ROM_LAT - 1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  blit_delay_line #(
    .DEPTH (ROM_LAT),
    .WIDTH (DLW)
  ) u_delay (
    .clk    (clk),
    .resetn (resetn),
    .din    (dl_in),
    .dout   (dl_out)
  );

  assign pix_valid  = dl_out[DLW-1];
  assign pix_x_full = dl_out[DLW-2 -: X_W+1];
  assign pix_y_full = dl_out[Y_W:0];

  assign is_key = (TRANSP_EN != 0) && (rom_data == COLOUR_W'(TRANSP_KEY));
  // Unwrapped sums are compared so sprites hanging off the right/bottom edge clip instead of wrapping.
  assign plot   = pix_valid && !is_key
                  && (pix_x_full < (X_W+1)'(SCREEN_W))
                  && (pix_y_full < (Y_W+1)'(SCREEN_H));
  assign x      = pix_x_full[X_W-1:0];
  assign y      = pix_y_full[Y_W-1:0];
  assign colour = pix_valid ? rom_data : '0;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed self-checking bench for sprite_blitter (4x2 image, ROM_LAT=1)
module tb_sprite_blitter;

  localparam int NCYC = 24;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pos_x = '0;
  logic [6:0] pos_y = '0;
  logic       flip_x = 1'b0;
  logic [2:0] rom_addr;
  logic [8:0] rom_data;
  logic [7:0] x;
  logic [6:0] y;
  logic [8:0] colour;
  logic       plot, busy, done;

  logic [8:0] rom [8];

  int checks = 0;
  int failures = 0;

  logic       plot_q [NCYC];
  logic       busy_q [NCYC];
  logic       done_q [NCYC];
  logic [7:0] x_q    [NCYC];
  logic [6:0] y_q    [NCYC];
  logic [8:0] col_q  [NCYC];

  sprite_blitter #(
    .IMG_W   (4),
    .IMG_H   (2),
    .ROM_LAT (1)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .flip_x   (flip_x),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic load_rom();
    for (int i = 0; i < 8; i++) rom[i] = 9'(i + 1);
  endtask

  // Start pulse occupies cycle 0; cycle c is sampled at the negedge after the c-th following edge.
  task automatic run_blit(input logic [7:0] px, input logic [6:0] py, input logic fx,
                          input logic [NCYC-1:0] start_mask, input int rst_cycle);
    @(negedge clk);
    pos_x = px; pos_y = py; flip_x = fx; start = 1'b1;
    for (int c = 1; c < NCYC; c++) begin
      @(negedge clk);
      start = start_mask[c];
      resetn = 1'b1;
      plot_q[c] = plot; busy_q[c] = busy; done_q[c] = done;
      x_q[c] = x; y_q[c] = y; col_q[c] = colour;
      if (c == rst_cycle) resetn = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({plot, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", {plot, busy, done});
    end
    checks++;
    if ({x, y, colour, rom_addr} !== '0) begin
      failures++;
      $display("FAIL reset_data x=%0d y=%0d colour=%0d rom_addr=%0d exp all 0", x, y, colour, rom_addr);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic(input string tag);
    load_rom();
    run_blit(8'd10, 7'd20, 1'b0, '0, -1);
    for (int c = 1; c < NCYC; c++) begin
      int  i;
      logic ep;
      i  = c - 2;
      ep = (c >= 2 && c <= 9);
      checks++;
      if (plot_q[c] !== ep) begin
        failures++;
        $display("FAIL %s_plot c=%0d got=%b exp=%b", tag, c, plot_q[c], ep);
      end
      if (ep) begin
        checks++;
        if (x_q[c] !== 8'(10 + i % 4) || y_q[c] !== 7'(20 + i / 4) || col_q[c] !== 9'(i + 1)) begin
          failures++;
          $display("FAIL %s_pixel c=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", tag, c,
                   x_q[c], y_q[c], col_q[c], 10 + i % 4, 20 + i / 4, i + 1);
        end
      end
      checks++;
      if (done_q[c] !== (c == 10) || busy_q[c] !== (c >= 1 && c <= 10)) begin
        failures++;
        $display("FAIL %s_handshake c=%0d got done=%b busy=%b exp done=%b busy=%b", tag, c,
                 done_q[c], busy_q[c], c == 10, c >= 1 && c <= 10);
      end
    end
  endtask

  task automatic test_transparent();
    load_rom();
    rom[1] = 9'd0;
    run_blit(8'd10, 7'd20, 1'b0, '0, -1);
    for (int c = 2; c <= 9; c++) begin
      checks++;
      if (plot_q[c] !== (c != 3)) begin
        failures++;
        $display("FAIL transp_plot c=%0d got=%b exp=%b", c, plot_q[c], c != 3);
      end
    end
    checks++;
    if (x_q[3] !== 8'd11 || y_q[3] !== 7'd20) begin
      failures++;
      $display("FAIL transp_coord got=(%0d,%0d) exp=(11,20)", x_q[3], y_q[3]);
    end
    checks++;
    if (done_q[10] !== 1'b1) begin
      failures++;
      $display("FAIL transp_done got=%b exp=1", done_q[10]);
    end
  endtask

  task automatic test_clip();
    load_rom();
    run_blit(8'd158, 7'd20, 1'b0, '0, -1);
    for (int c = 2; c <= 9; c++) begin
      logic ep;
      ep = ((c - 2) % 4) < 2;
      checks++;
      if (plot_q[c] !== ep) begin
        failures++;
        $display("FAIL clip_plot c=%0d x=%0d got=%b exp=%b", c, x_q[c], plot_q[c], ep);
      end
    end
    checks++;
    if (x_q[3] !== 8'd159 || col_q[3] !== 9'd2) begin
      failures++;
      $display("FAIL clip_edge got x=%0d colour=%0d exp x=159 colour=2", x_q[3], col_q[3]);
    end
    checks++;
    if (done_q[10] !== 1'b1 || done_q[9] !== 1'b0) begin
      failures++;
      $display("FAIL clip_done got c9=%b c10=%b exp c9=0 c10=1", done_q[9], done_q[10]);
    end
  endtask

  task automatic test_flip();
    load_rom();
    run_blit(8'd10, 7'd20, 1'b1, '0, -1);
    for (int c = 2; c <= 9; c++) begin
      int i;
      int ec;
      i  = c - 2;
      ec = (i / 4) * 4 + (3 - i % 4) + 1;
      checks++;
      if (plot_q[c] !== 1'b1 || x_q[c] !== 8'(10 + i % 4) || y_q[c] !== 7'(20 + i / 4) || col_q[c] !== 9'(ec)) begin
        failures++;
        $display("FAIL flip_pixel c=%0d got=(%0d,%0d,%0d,plot=%b) exp=(%0d,%0d,%0d,plot=1)", c,
                 x_q[c], y_q[c], col_q[c], plot_q[c], 10 + i % 4, 20 + i / 4, ec);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    load_rom();
    run_blit(8'd10, 7'd20, 1'b0, NCYC'((1 << 3) | (1 << 10) | (1 << 11)), -1);
    ndone = 0;
    for (int c = 1; c <= 11; c++) if (done_q[c] === 1'b1) ndone++;
    checks++;
    if (ndone != 1 || done_q[10] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_single_done got count=%0d c10=%b exp count=1 c10=1", ndone, done_q[10]);
    end
    checks++;
    if (busy_q[11] !== 1'b0 || busy_q[12] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart_busy got c11=%b c12=%b exp c11=0 c12=1", busy_q[11], busy_q[12]);
    end
    checks++;
    if (plot_q[13] !== 1'b1 || x_q[13] !== 8'd10 || col_q[13] !== 9'd1) begin
      failures++;
      $display("FAIL b2b_second_first_pixel got plot=%b x=%0d colour=%0d exp plot=1 x=10 colour=1",
               plot_q[13], x_q[13], col_q[13]);
    end
    checks++;
    if (done_q[21] !== 1'b1 || done_q[20] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_done got c20=%b c21=%b exp c20=0 c21=1", done_q[20], done_q[21]);
    end
  endtask

  task automatic test_reset_mid_blit();
    load_rom();
    run_blit(8'd10, 7'd20, 1'b0, '0, 5);
    checks++;
    if (plot_q[2] !== 1'b1 || busy_q[5] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_before got plot2=%b busy5=%b exp 1 1", plot_q[2], busy_q[5]);
    end
    for (int c = 6; c < NCYC; c++) begin
      checks++;
      if (plot_q[c] !== 1'b0 || busy_q[c] !== 1'b0 || done_q[c] !== 1'b0) begin
        failures++;
        $display("FAIL midrst_after c=%0d got plot=%b busy=%b done=%b exp 0 0 0", c,
                 plot_q[c], busy_q[c], done_q[c]);
      end
    end
    test_basic("post_reset");
  endtask

  initial begin
    load_rom();
    test_reset();
    test_basic("basic");
    test_transparent();
    test_clip();
    test_flip();
    test_back_to_back();
    test_reset_mid_blit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
